// File: rtl/operand_bypass_unit.sv
// operand_bypass_unit
// Operand forwarding and load-use hazard detection for the EX stage.
// A small tag pipeline records the destination register, write-enable,
// load and link flags of every instruction in flight after EX. Each ALU
// source is taken from the youngest matching stage (ALU result or PC+4),
// or from the register file or immediate when no stage matches. A stall
// is raised when the youngest match is a load that has not reached the
// last tracked slot, because its data does not exist yet.
module operand_bypass_unit #(
  parameter int XLEN    = 32,
  parameter int NUM_SRC = 2,
  parameter int DEPTH   = 2,
  parameter int RA_W    = 5,
  parameter int SEL_W   = $clog2(DEPTH + 1)
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     pipe_en,
  input  logic                     flush,
  input  logic                     issue_valid,
  input  logic [RA_W-1:0]          issue_rd,
  input  logic                     issue_we,
  input  logic                     issue_is_load,
  input  logic                     issue_is_link,
  input  logic [NUM_SRC*RA_W-1:0]  src_addr,
  input  logic [NUM_SRC-1:0]       src_used,
  input  logic [NUM_SRC-1:0]       src_use_imm,
  input  logic [NUM_SRC*XLEN-1:0]  src_rf_data,
  input  logic [XLEN-1:0]          imm,
  input  logic [DEPTH*XLEN-1:0]    stage_wdata,
  input  logic [DEPTH*XLEN-1:0]    stage_link,
  output logic [NUM_SRC*XLEN-1:0]  operand,
  output logic [NUM_SRC*SEL_W-1:0] fwd_sel,
  output logic                     stall,
  output logic [31:0]              stall_cnt
);

  // Tag slots: index 0 is the EX/MEM entry, DEPTH-1 the MEM/WB entry.
  logic [DEPTH-1:0] r_valid;
  logic [DEPTH-1:0] r_we;
  logic [DEPTH-1:0] r_is_load;
  logic [DEPTH-1:0] r_is_link;
  logic [RA_W-1:0]  r_rd [DEPTH];
  logic [31:0]      r_stall_cnt;

  logic [NUM_SRC*XLEN-1:0]  w_operand;
  logic [NUM_SRC*SEL_W-1:0] w_fwd_sel;
  logic                     w_stall;

  // Per-source operand selection: youngest matching slot wins, else RF/imm.
  always_comb begin
    logic [RA_W-1:0] w_addr;
    logic [XLEN-1:0] w_data;
    logic [SEL_W-1:0] w_sel;
    logic            w_load_hit;
    // NOTE: every combinational output gets a default before any branch so
    // no path leaves a value unassigned and no latch is inferred.
    w_operand  = '0;
    w_fwd_sel  = '0;
    w_stall    = 1'b0;
    w_addr     = '0;
    w_data     = '0;
    w_sel      = '0;
    w_load_hit = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      w_addr     = src_addr[i*RA_W +: RA_W];
      w_data     = src_use_imm[i] ? imm : src_rf_data[i*XLEN +: XLEN];
      w_sel      = '0;
      w_load_hit = 1'b0;
      // Walk oldest to youngest so the youngest match overwrites the rest.
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (r_valid[k] && r_we[k] && (r_rd[k] == w_addr) && (w_addr != '0) &&
            src_used[i] && !src_use_imm[i]) begin
          w_sel      = SEL_W'(k + 1);
          w_data     = r_is_link[k] ? stage_link[k*XLEN +: XLEN]
                                    : stage_wdata[k*XLEN +: XLEN];
          w_load_hit = r_is_load[k] && (k < DEPTH - 1);
        end
      end
      w_operand[i*XLEN +: XLEN]   = w_data;
      w_fwd_sel[i*SEL_W +: SEL_W] = w_sel;
      w_stall                     = w_stall | w_load_hit;
    end
  end

  // Tag pipeline: shift on pipe_en, inserting the issued instruction or a bubble.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      // NOTE: the tag array is a handful of flops, not a RAM, so every field
      // is reset; only valid matters functionally, the rest keeps X out of sim.
      r_valid   <= '0;
      r_we      <= '0;
      r_is_load <= '0;
      r_is_link <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_rd[k] <= '0;
      end
    end else if (pipe_en) begin
      // NOTE: non-blocking assignments make every slot read its neighbour's
      // pre-edge value, so the shift order inside the loop does not matter.
      for (int k = DEPTH - 1; k > 0; k--) begin
        r_valid[k]   <= r_valid[k-1];
        r_we[k]      <= r_we[k-1];
        r_is_load[k] <= r_is_load[k-1];
        r_is_link[k] <= r_is_link[k-1];
        r_rd[k]      <= r_rd[k-1];
      end
      // A stalled or flushed issue becomes a bubble in slot 0.
      r_valid[0]   <= issue_valid & ~flush & ~w_stall;
      r_we[0]      <= issue_we;
      r_is_load[0] <= issue_is_load;
      r_is_link[0] <= issue_is_link;
      r_rd[0]      <= issue_rd;
    end
  end

  // Saturating count of cycles in which the pipeline advanced under a stall.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_stall_cnt <= '0;
    end else if (pipe_en && w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign operand   = w_operand;
  assign fwd_sel   = w_fwd_sel;
  assign stall     = w_stall;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_operand_bypass_unit.sv
// tb_operand_bypass_unit
// Scenario bench for operand_bypass_unit (XLEN=32, NUM_SRC=2, DEPTH=2).
// Each scenario drives stimulus, pushes the expected observation to a
// scoreboard queue and pops it at the following falling edge.
module tb_operand_bypass_unit;

  localparam int XLEN    = 32;
  localparam int NUM_SRC = 2;
  localparam int DEPTH   = 2;
  localparam int RA_W    = 5;
  localparam int SEL_W   = 2;

  logic                     CLK;
  logic                     RSTn;
  logic                     pipe_en;
  logic                     flush;
  logic                     issue_valid;
  logic [RA_W-1:0]          issue_rd;
  logic                     issue_we;
  logic                     issue_is_load;
  logic                     issue_is_link;
  logic [NUM_SRC*RA_W-1:0]  src_addr;
  logic [NUM_SRC-1:0]       src_used;
  logic [NUM_SRC-1:0]       src_use_imm;
  logic [NUM_SRC*XLEN-1:0]  src_rf_data;
  logic [XLEN-1:0]          imm;
  logic [DEPTH*XLEN-1:0]    stage_wdata;
  logic [DEPTH*XLEN-1:0]    stage_link;
  logic [NUM_SRC*XLEN-1:0]  operand;
  logic [NUM_SRC*SEL_W-1:0] fwd_sel;
  logic                     stall;
  logic [31:0]              stall_cnt;

  typedef struct packed {
    logic [31:0] op0;
    logic [31:0] op1;
    logic [1:0]  sel0;
    logic [1:0]  sel1;
    logic        stl;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_total = 0;
  int    n_pass  = 0;

  operand_bypass_unit #(
    .XLEN(XLEN), .NUM_SRC(NUM_SRC), .DEPTH(DEPTH), .RA_W(RA_W), .SEL_W(SEL_W)
  ) dut (
    .CLK(CLK), .RSTn(RSTn), .pipe_en(pipe_en), .flush(flush),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_we(issue_we),
    .issue_is_load(issue_is_load), .issue_is_link(issue_is_link),
    .src_addr(src_addr), .src_used(src_used), .src_use_imm(src_use_imm),
    .src_rf_data(src_rf_data), .imm(imm), .stage_wdata(stage_wdata),
    .stage_link(stage_link), .operand(operand), .fwd_sel(fwd_sel),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic [4:0] rd, input logic we,
                           input logic ld, input logic lk, input logic fl);
    issue_valid = v; issue_rd = rd; issue_we = we;
    issue_is_load = ld; issue_is_link = lk; flush = fl;
  endtask

  task automatic set_src(input int i, input logic [4:0] a, input logic used,
                         input logic use_imm, input logic [31:0] rf);
    src_addr[i*RA_W +: RA_W]    = a;
    src_used[i]                 = used;
    src_use_imm[i]              = use_imm;
    src_rf_data[i*XLEN +: XLEN] = rf;
  endtask

  task automatic set_stage(input int k, input logic [31:0] wd, input logic [31:0] lk);
    stage_wdata[k*XLEN +: XLEN] = wd;
    stage_link[k*XLEN +: XLEN]  = lk;
  endtask

  task automatic clear_inputs();
    set_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    src_addr = '0; src_used = '0; src_use_imm = '0; src_rf_data = '0;
    imm = '0; stage_wdata = '0; stage_link = '0;
  endtask

  task automatic drain();
    clear_inputs();
    step();
    step();
  endtask

  task automatic push_exp(input string nm, input logic [31:0] op0, input logic [31:0] op1,
                          input logic [1:0] s0, input logic [1:0] s1,
                          input logic st, input logic [31:0] cnt);
    exp_t e;
    e = '{op0: op0, op1: op1, sel0: s0, sel1: s1, stl: st, cnt: cnt};
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    exp_t e, got; string nm;
    RSTn = 1'b0; pipe_en = 1'b1;
    clear_inputs();
    repeat (2) @(posedge CLK);
    #1 RSTn = 1'b1;
    set_src(0, 5'd5, 1'b1, 1'b0, 32'h11);
    set_src(1, 5'd3, 1'b1, 1'b1, 32'h99);
    imm = 32'h55;
    push_exp("reset_state", 32'h11, 32'h55, 2'd0, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_forward();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    set_src(0, 5'd5, 1'b1, 1'b0, 32'h0);
    set_stage(0, 32'hAB, 32'h0);
    push_exp("fwd_slot0", 32'hAB, 32'h0, 2'd1, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    set_stage(0, 32'h0, 32'h0);
    set_stage(1, 32'hAB, 32'h0);
    push_exp("fwd_slot1", 32'hAB, 32'h0, 2'd2, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    set_src(0, 5'd5, 1'b1, 1'b0, 32'h33);
    push_exp("fwd_retired", 32'h33, 32'h0, 2'd0, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_back_to_back();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    step();
    clear_inputs();
    set_stage(0, 32'h2, 32'h0);
    set_stage(1, 32'h1, 32'h0);
    set_src(0, 5'd7, 1'b1, 1'b0, 32'h0);
    set_src(1, 5'd7, 1'b1, 1'b1, 32'h0);
    imm = 32'h77;
    push_exp("youngest_wins_imm", 32'h2, 32'h77, 2'd1, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_link();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd1, 1'b1, 1'b0, 1'b1, 1'b0);
    step();
    clear_inputs();
    set_stage(0, 32'hDEAD, 32'h104);
    set_src(0, 5'd1, 1'b1, 1'b0, 32'h0);
    push_exp("link_slot0", 32'h104, 32'h0, 2'd1, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    set_stage(0, 32'h0, 32'h0);
    set_stage(1, 32'hBEEF, 32'h204);
    push_exp("link_slot1", 32'h204, 32'h0, 2'd2, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_load_use();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    clear_inputs();
    // The consumer tries to issue while the load sits in slot 0.
    set_issue(1'b1, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
    set_src(0, 5'd9, 1'b1, 1'b0, 32'h0);
    set_stage(0, 32'h5A, 32'h0);
    push_exp("load_use_stall", 32'h5A, 32'h0, 2'd1, 2'd0, 1'b1, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    set_stage(0, 32'h0, 32'h0);
    set_stage(1, 32'h9999, 32'h0);
    push_exp("load_use_fwd_wb", 32'h9999, 32'h0, 2'd2, 2'd0, 1'b0, 32'd1);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    clear_inputs();
    set_src(0, 5'd10, 1'b1, 1'b0, 32'h0);
    set_stage(0, 32'hA10, 32'h0);
    push_exp("consumer_issued", 32'hA10, 32'h0, 2'd1, 2'd0, 1'b0, 32'd1);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_flush_and_stall();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    clear_inputs();
    set_issue(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1);
    set_src(0, 5'd9, 1'b1, 1'b0, 32'h0);
    set_stage(0, 32'h1, 32'h0);
    push_exp("flush_stall_a", 32'h1, 32'h0, 2'd1, 2'd0, 1'b1, 32'd1);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    set_issue(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    set_stage(0, 32'h0, 32'h0);
    set_stage(1, 32'h2, 32'h0);
    set_src(1, 5'd11, 1'b1, 1'b0, 32'h1111);
    push_exp("flush_stall_b", 32'h2, 32'h1111, 2'd2, 2'd0, 1'b0, 32'd2);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_x0();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    step();
    clear_inputs();
    set_src(0, 5'd0, 1'b1, 1'b0, 32'h123);
    set_stage(0, 32'hBAD, 32'h0);
    push_exp("x0_not_forwarded", 32'h123, 32'h0, 2'd0, 2'd0, 1'b0, 32'd2);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_flush();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    clear_inputs();
    set_src(0, 5'd12, 1'b1, 1'b0, 32'hF0);
    set_stage(0, 32'hBAD, 32'h0);
    push_exp("flushed_slot0", 32'hF0, 32'h0, 2'd0, 2'd0, 1'b0, 32'd2);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    set_stage(1, 32'hBAD, 32'h0);
    push_exp("flushed_slot1", 32'hF0, 32'h0, 2'd0, 2'd0, 1'b0, 32'd2);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_freeze();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd13, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    clear_inputs();
    set_src(0, 5'd13, 1'b1, 1'b0, 32'h0);
    set_stage(0, 32'h13, 32'h0);
    push_exp("freeze_before", 32'h13, 32'h0, 2'd1, 2'd0, 1'b1, 32'd2);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    pipe_en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      step();
      push_exp($sformatf("freeze_hold_%0d", c), 32'h13, 32'h0, 2'd1, 2'd0, 1'b1, 32'd2);
      @(negedge CLK);
      e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
      got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
      if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
      else n_pass++;
    end
    pipe_en = 1'b1;
    step();
    set_stage(0, 32'h0, 32'h0);
    set_stage(1, 32'h1313, 32'h0);
    push_exp("freeze_release", 32'h1313, 32'h0, 2'd2, 2'd0, 1'b0, 32'd3);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  task automatic test_reset_mid();
    exp_t e, got; string nm;
    set_issue(1'b1, 5'd14, 1'b1, 1'b1, 1'b0, 1'b0);
    step();
    clear_inputs();
    set_src(0, 5'd14, 1'b1, 1'b0, 32'h44);
    set_stage(0, 32'h14, 32'h0);
    push_exp("pre_reset", 32'h14, 32'h0, 2'd1, 2'd0, 1'b1, 32'd3);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    #2 RSTn = 1'b0;
    push_exp("in_reset", 32'h44, 32'h0, 2'd0, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    step();
    RSTn = 1'b1;
    push_exp("after_reset", 32'h44, 32'h0, 2'd0, 2'd0, 1'b0, 32'd0);
    @(negedge CLK);
    e = exp_q.pop_front(); nm = name_q.pop_front(); n_total++;
    got = {operand[31:0], operand[63:32], fwd_sel[1:0], fwd_sel[3:2], stall, stall_cnt};
    if (got !== e) $display("FAIL %s: got op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d, expected op0=%h op1=%h sel0=%0d sel1=%0d stall=%b cnt=%0d", nm, got.op0, got.op1, got.sel0, got.sel1, got.stl, got.cnt, e.op0, e.op1, e.sel0, e.sel1, e.stl, e.cnt);
    else n_pass++;
    drain();
  endtask

  initial begin
    test_reset();
    test_forward();
    test_back_to_back();
    test_link();
    test_load_use();
    test_flush_and_stall();
    test_x0();
    test_flush();
    test_freeze();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
